div8bit_seq: RTL



---
 rtl/div8bit_seq_if.sv | 30 +++
 rtl/div8bit_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/div8bit_seq_if.sv
// rtl/div8bit_seq_if.sv - handshake/operand bundle for div8bit_seq; is_signed exists only with DIV8_SIGNED_EN
interface div8bit_seq_if;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
`ifdef DIV8_SIGNED_EN
  logic       is_signed;
`endif
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;

  modport master (
`ifdef DIV8_SIGNED_EN
    output is_signed,
`endif
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
`ifdef DIV8_SIGNED_EN
    input  is_signed,
`endif
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div8bit_seq.sv
// rtl/div8bit_seq.sv - 8-bit sequential restoring divider, one quotient bit per cycle
// Signed two's-complement support is compiled in with DIV8_SIGNED_EN.
module div8bit_seq (
  input  logic         clk,
  input  logic         rst_n,
  div8bit_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
`ifdef DIV8_SIGNED_EN
    , FIX = 2'd3
`endif
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] count;
  logic [7:0] quo_w, rem_w, dvs;
  logic [7:0] quotient, remainder;
  logic       div_zero;
  logic [8:0] partial;
  logic       step_ok;
  logic [7:0] sub, rem_nxt, quo_nxt;
  logic [7:0] mag_dividend, mag_divisor;
  logic       last_iter;

`ifdef DIV8_SIGNED_EN
  logic work_signed, neg_q, neg_r;
  assign mag_dividend = (bus.is_signed && bus.dividend[7]) ? (~bus.dividend + 8'd1) : bus.dividend;
  assign mag_divisor  = (bus.is_signed && bus.divisor[7])  ? (~bus.divisor + 8'd1)  : bus.divisor;
`else
  assign mag_dividend = bus.dividend;
  assign mag_divisor  = bus.divisor;
`endif

  assign last_iter = (count == 3'd0);

  // The true difference is always below dvs, so 8-bit wraparound subtraction yields it exactly.
  always_comb begin
    partial = {rem_w, quo_w[7]};
    step_ok = (partial >= {1'b0, dvs});
    sub     = partial[7:0] - dvs;
    rem_nxt = step_ok ? sub : partial[7:0];
    quo_nxt = {quo_w[6:0], step_ok};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.divisor == 8'd0) ? DONE : CALC;
      CALC: begin
        if (last_iter) begin
`ifdef DIV8_SIGNED_EN
          state_nxt = work_signed ? FIX : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef DIV8_SIGNED_EN
      FIX:  state_nxt = DONE;
`endif
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= 3'd0;
      quo_w     <= 8'd0;
      rem_w     <= 8'd0;
      dvs       <= 8'd0;
      quotient  <= 8'd0;
      remainder <= 8'd0;
      div_zero  <= 1'b0;
`ifdef DIV8_SIGNED_EN
      work_signed <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            quo_w    <= mag_dividend;
            rem_w    <= 8'd0;
            dvs      <= mag_divisor;
            count    <= 3'd7;
            div_zero <= (bus.divisor == 8'd0);
`ifdef DIV8_SIGNED_EN
            work_signed <= bus.is_signed;
            neg_q       <= bus.is_signed && (bus.dividend[7] ^ bus.divisor[7]);
            neg_r       <= bus.is_signed && bus.dividend[7];
`endif
            // Divide-by-zero results are final at capture; CALC is skipped entirely.
            if (bus.divisor == 8'd0) begin
              quotient  <= 8'hFF;
              remainder <= bus.dividend;
            end
          end
        end
        CALC: begin
          quo_w <= quo_nxt;
          rem_w <= rem_nxt;
          count <= count - 3'd1;
`ifdef DIV8_SIGNED_EN
          if (last_iter && !work_signed) begin
`else
          if (last_iter) begin
`endif
            quotient  <= quo_nxt;
            remainder <= rem_nxt;
          end
        end
`ifdef DIV8_SIGNED_EN
        FIX: begin
          quotient  <= neg_q ? (~quo_w + 8'd1) : quo_w;
          remainder <= neg_r ? (~rem_w + 8'd1) : rem_w;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef DIV8_SIGNED_EN
  assign bus.busy = (state == CALC) || (state == FIX);
`else
  assign bus.busy = (state == CALC);
`endif
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  assign bus.div_zero  = div_zero;

endmodule
